// File: rtl/mips_alu_pkg.sv
// Shared ALU control codes and the multiply sequencer state encoding.
package mips_alu_pkg;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } mult_state_e;

endpackage

// File: rtl/mult_sequencer.sv
// Shift-add 32x32 unsigned multiplier that borrows the shared ALU for one add per cycle.
module mult_sequencer
  import mips_alu_pkg::*;
#(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [31:0] alu_result,
  output logic        alu_own,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mult_state_e state;
  logic [4:0]  cnt;
  logic [31:0] mcand;
  logic        carry;
  logic        last_iter;

  // The ALU is 32 bits wide, so the add's carry-out is recovered by unsigned wrap detection.
  assign carry     = (alu_result < hi);
  assign last_iter = (cnt == 5'(ITER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StIdle;
      cnt   <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            mcand <= operand_a;
            hi    <= '0;
            lo    <= operand_b;
            cnt   <= '0;
            state <= StCalc;
          end
        end
        StCalc: begin
          if (abort) begin
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            state <= StIdle;
          end else begin
            hi  <= {carry, alu_result[31:1]};
            lo  <= {alu_result[0], lo[31:1]};
            cnt <= cnt + 5'd1;
            if (last_iter) begin
              state <= StDone;
            end
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign busy = (state == StCalc);
  assign done = (state == StDone);

  always_comb begin
    alu_own  = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = AluAnd;
    if (state == StCalc) begin
      alu_own  = 1'b1;
      alu_a    = hi;
      alu_b    = lo[0] ? mcand : '0;
      alu_ctrl = AluAdd;
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer with a behavioural ALU model.
module tb_mult_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] alu_result;
  logic        alu_own;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;
  int done_total = 0;
  int own_cycles = 0;
  int b_nonzero  = 0;

  logic [63:0] exp_q[$];

  mult_sequencer #(.ITER(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .alu_result(alu_result),
    .alu_own   (alu_own),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  // Shared ALU: only the add operation matters here.
  assign alu_result = (alu_ctrl == 4'b0010) ? (alu_a + alu_b) : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop the expected product on every done pulse.
  always @(negedge clk) begin
    if (alu_own) begin
      own_cycles++;
      if (alu_b != 32'h0) b_nonzero++;
    end
    if (done === 1'b1) begin
      done_total++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got hi=0x%0h lo=0x%0h expected no done", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({hi, lo} !== e) begin
          failures++;
          $display("FAIL product: got 0x%0h expected 0x%0h", {hi, lo}, e);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 100);
    check({name, "_latency"}, 64'(n), 64'(exp_lat));
    @(negedge clk);
    check({name, "_done_one_cycle"}, {63'h0, done}, 64'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    operand_a = '0;
    operand_b = '0;
    #12;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_alu_own", {63'h0, alu_own}, 64'h0);
    check("rst_alu_ctrl", {60'h0, alu_ctrl}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 3 * 5
    exp_q.push_back(64'h0000_0000_0000_000F);
    issue(32'd3, 32'd5);
    check("busy_after_start", {63'h0, busy}, 64'h1);
    check("alu_ctrl_add", {60'h0, alu_ctrl}, 64'h2);
    wait_done("mul_3x5", 32);

    // Carry path
    exp_q.push_back(64'hFFFF_FFFE_0000_0001);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mul_max", 32);
    check("idle_after_done", {63'h0, busy}, 64'h0);

    // Zero multiplier: ALU operand b stays zero, ALU owned exactly 32 cycles
    own_cycles = 0;
    b_nonzero  = 0;
    exp_q.push_back(64'h0);
    issue(32'h1234_5678, 32'h0);
    wait_done("mul_zero", 32);
    check("own_cycles", 64'(own_cycles), 64'd32);
    check("alu_b_zero", 64'(b_nonzero), 64'd0);

    // Start re-pulsed mid-operation is ignored
    exp_q.push_back(64'h0000_0001_0002_0001);
    issue(32'h0001_0001, 32'h0001_0001);
    repeat (9) @(negedge clk);
    operand_a = 32'h0000_00FF;
    operand_b = 32'h0000_0100;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mul_restart", 22);

    // Abort with cnt == 31 beats the final transition
    issue(32'd9, 32'd9);
    repeat (31) @(negedge clk);
    check("busy_before_abort", {63'h0, busy}, 64'h1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_done", {63'h0, done}, 64'h0);
    check("abort_hilo", {hi, lo}, 64'h0);
    repeat (3) @(negedge clk);
    exp_q.push_back(64'd42);
    issue(32'd7, 32'd6);
    wait_done("mul_7x6", 32);

    // Asynchronous reset mid-operation
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (15) @(negedge clk);
    check("pre_reset_hi_nonzero", {63'h0, (hi != 32'h0)}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_hilo", {hi, lo}, 64'h0);
    check("async_rst_busy", {63'h0, busy}, 64'h0);
    check("async_rst_own", {63'h0, alu_own}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_idle", {63'h0, busy}, 64'h0);

    check("done_total", 64'(done_total), 64'd5);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL expose parameter ITER, default 32, meaning the number of shift-add iterations and the operand width; only 32 is supported.
REQ-002 SHALL expose port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL expose port rst_n, input, 1, the reset; asynchronous, active-low.
REQ-004 SHALL expose port start, input, 1, the request to begin a multiply.
REQ-005 SHALL expose port abort, input, 1, a synchronous cancel of the operation in flight.
REQ-006 SHALL expose port operand_a, input, 32, the unsigned multiplicand.
REQ-007 SHALL expose port operand_b, input, 32, the unsigned multiplier.
REQ-008 SHALL expose port alu_result, input, 32, the result returned by the shared ALU in the same cycle.
REQ-009 SHALL expose port alu_own, output, 1; when high, the datapath ALU input mux selects this block.
REQ-010 SHALL expose port alu_a, output, 32, the ALU Read_data1 operand.
REQ-011 SHALL expose port alu_b, output, 32, the ALU Read_data2 operand.
REQ-012 SHALL expose port alu_ctrl, output, 4, the ALU_Control code.
REQ-013 SHALL expose port busy, output, 1, high while iterating.
REQ-014 SHALL expose port done, output, 1, a one-cycle completion pulse.
REQ-015 SHALL expose port hi, output, 32, the upper product word.
REQ-016 SHALL expose port lo, output, 32, the lower product word.

Function
REQ-017 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-018 SHALL accept start only in IDLE; start is ignored in CALC and DONE.
REQ-019 On an accepted start, the block SHALL load: mcand <= operand_a, hi <= 0, lo <= operand_b, cnt <= 0, and move to CALC.
REQ-020 In CALC, the block SHALL drive alu_own=1, alu_ctrl=4'b0010 (add), alu_a=hi, and alu_b = lo[0] ? mcand : 0; all combinational from registers.
REQ-021 Each CALC cycle, the block SHALL compute carry = (alu_result < hi) unsigned, then update hi <= {carry, alu_result[31:1]}, lo <= {alu_result[0], lo[31:1]}, cnt <= cnt+1.
REQ-022 When cnt==ITER-1 in CALC, the block SHALL move to DONE after that edge's update; CALC lasts exactly 32 cycles.
REQ-023 In DONE, the block SHALL assert done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-024 done SHALL first be high in the cycle following the 32nd rising edge after the start-accepting edge; start-to-done latency is 33 edges.
REQ-025 busy SHALL be 1 exactly when state==CALC.
REQ-026 Outside CALC, the block SHALL drive alu_own=0, alu_a=0, alu_b=0 and alu_ctrl=4'b0000.
REQ-027 hi and lo SHALL hold the final product {hi,lo} = operand_a*operand_b (64-bit unsigned) from DONE until the next accepted start.
REQ-028 abort=1 in CALC SHALL force IDLE on the next edge, with hi<=0, lo<=0, cnt<=0 and no done pulse; abort outside CALC has no effect.
REQ-029 abort SHALL take priority over the cnt==ITER-1 transition when both occur in the same cycle.
REQ-030 cnt SHALL be 5 bits and SHALL never wrap within an operation.

Reset
REQ-031 While rst_n==0, the block SHALL asynchronously hold state=IDLE, cnt=0, mcand=0, hi=0, lo=0, done=0, busy=0 and alu_own=0.
REQ-032 Reset asserted mid-CALC SHALL discard the operation; after deassertion the block SHALL be in IDLE with no done pulse.
REQ-033 The first start SHALL be accepted on the first rising edge at which rst_n==1.

Structure
REQ-034 ALU control codes (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100) and the FSM state encoding SHALL live in the shared package mips_alu_pkg.
REQ-035 The block SHALL contain no sub-module; the ALU stays external and shared, selected via alu_own.

Verification
REQ-036 start with a=3, b=5 -> after 32 CALC cycles, done pulses once with hi=0x00000000, lo=0x0000000F.
REQ-037 a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; checks the carry path.
REQ-038 a=0x12345678, b=0 -> hi=0 and lo=0; alu_b=0 in every CALC cycle; alu_own high for exactly 32 cycles.
REQ-039 start re-pulsed at CALC cycle 10 with different operands -> ignored; result equals the first operation's product; done pulses only once.
REQ-040 abort at CALC cycle 31 (cnt==31) -> IDLE next cycle, hi=lo=0, no done; a following start with a=7, b=6 -> lo=42.
REQ-041 rst_n pulled low at CALC cycle 15 -> outputs zero immediately (asynchronously); no done after release.
